// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants: opcodes, ALUOp encodings and the control bundle
// carried from ID into EX.
package riscv_pkg;

  localparam int unsigned OPC_W     = 7;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned F3_W      = 3;
  localparam int unsigned F7_W      = 7;

  localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_ALUI   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_ADDI  = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // A bubble does nothing: add-type ALUOp, no memory access, no writeback.
  localparam ctrl_t CTRL_BUBBLE = '{alu_op: ALU_ADD, default: 1'b0};

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Combinational decode-slot checks: opcode legality, source-register usage and
// load-use hazard against the instruction currently in EX.
//   id_valid_i/id_opcode_i/id_rs1_i/id_rs2_i : decode slot
//   ex_valid_i/ex_mem_read_i/ex_rd_i         : current EX slot
//   opcode_known_o                           : opcode is one of the supported set
//   load_use_o                               : ID reads the register a load in EX writes
module id_ex_hazard_detect
  import riscv_pkg::*;
(
  input  logic                 id_valid_i,
  input  logic [OPC_W-1:0]     id_opcode_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_mem_read_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  output logic                 opcode_known_o,
  output logic                 load_use_o
);

  logic uses_rs1;
  logic uses_rs2;

  // Opcode classification
  always_comb begin
    opcode_known_o = 1'b0;
    uses_rs1       = 1'b0;
    uses_rs2       = 1'b0;
    case (id_opcode_i)
      OPC_R, OPC_STORE, OPC_BRANCH: begin
        opcode_known_o = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OPC_LOAD, OPC_ALUI, OPC_JALR: begin
        opcode_known_o = 1'b1;
        uses_rs1       = 1'b1;
      end
      OPC_AUIPC, OPC_LUI, OPC_JAL: begin
        opcode_known_o = 1'b1;
      end
      default: ;
    endcase
  end

  // x0 is never a real producer, so rd==0 cannot create a dependency
  assign load_use_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) & id_valid_i &
                      ((uses_rs1 & (id_rs1_i == ex_rd_i)) |
                       (uses_rs2 & (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with load-use bubble insertion, EX flush/hold,
// illegal-opcode sanitising and a saturating load-use bubble counter.
//   clk, rst (sync, active-high)
//   id_*        : decode-stage slot (valid, opcode/funct, control, operands, indices)
//   ex_flush    : kill the EX slot; ex_hold : freeze the EX slot
//   ex_*        : registered copy of the decode slot
//   stall_if_id : combinational request for IF/ID to hold
//   illegal_op  : one-cycle pulse when an unknown opcode was dropped
//   bubble_cnt  : saturating count of load-use bubbles
module id_ex_stage_reg
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [OPC_W-1:0]     id_opcode,
  input  logic [F3_W-1:0]      id_funct3,
  input  logic [F7_W-1:0]      id_funct7,
  input  logic [1:0]           id_alu_op,
  input  logic                 id_alu_src,
  input  logic                 id_branch,
  input  logic                 id_mem_write,
  input  logic                 id_mem_read,
  input  logic                 id_mem_to_reg,
  input  logic                 id_reg_write,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 ex_flush,
  input  logic                 ex_hold,
  output logic                 ex_valid,
  output logic [OPC_W-1:0]     ex_opcode,
  output logic [F3_W-1:0]      ex_funct3,
  output logic [F7_W-1:0]      ex_funct7,
  output logic [1:0]           ex_alu_op,
  output logic                 ex_alu_src,
  output logic                 ex_branch,
  output logic                 ex_mem_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_to_reg,
  output logic                 ex_reg_write,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic                 stall_if_id,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef struct packed {
    logic                 valid;
    logic [OPC_W-1:0]     opcode;
    logic [F3_W-1:0]      funct3;
    logic [F7_W-1:0]      funct7;
    ctrl_t                ctrl;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      imm;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_t            slot_q, slot_d, id_slot, bubble_slot;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             opcode_known;
  logic             load_use;

  id_ex_hazard_detect u_hazard (
    .id_valid_i     (id_valid),
    .id_opcode_i    (id_opcode),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .ex_valid_i     (slot_q.valid),
    .ex_mem_read_i  (slot_q.ctrl.mem_read),
    .ex_rd_i        (slot_q.rd),
    .opcode_known_o (opcode_known),
    .load_use_o     (load_use)
  );

  // Decode slot as presented by ID
  always_comb begin
    id_slot          = '0;
    id_slot.valid    = id_valid;
    id_slot.opcode   = id_opcode;
    id_slot.funct3   = id_funct3;
    id_slot.funct7   = id_funct7;
    id_slot.ctrl     = '{alu_op: id_alu_op, alu_src: id_alu_src, branch: id_branch,
                         mem_write: id_mem_write, mem_read: id_mem_read,
                         mem_to_reg: id_mem_to_reg, reg_write: id_reg_write};
    id_slot.pc       = id_pc;
    id_slot.rs1_data = id_rs1_data;
    id_slot.rs2_data = id_rs2_data;
    id_slot.imm      = id_imm;
    id_slot.rs1      = id_rs1;
    id_slot.rs2      = id_rs2;
    id_slot.rd       = id_rd;
  end

  // Bubble: invalid, inert control, data zeroed
  always_comb begin
    bubble_slot      = '0;
    bubble_slot.ctrl = CTRL_BUBBLE;
  end

  // Priority mux: flush > hold > load-use > illegal/invalid > load
  always_comb begin
    slot_d    = slot_q;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;
    if (ex_flush) begin
      slot_d = bubble_slot;
    end else if (ex_hold) begin
      slot_d = slot_q;
    end else if (load_use) begin
      slot_d = bubble_slot;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (id_valid && !opcode_known) begin
      slot_d    = bubble_slot;
      illegal_d = 1'b1;
    end else if (!id_valid) begin
      // Controls of an empty slot may be garbage; never capture them
      slot_d = bubble_slot;
    end else begin
      slot_d = id_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      slot_q    <= slot_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // Reset and flush override; upstream is cleared elsewhere in those cases
  assign stall_if_id = ~rst & ~ex_flush & (ex_hold | load_use);

  assign ex_valid      = slot_q.valid;
  assign ex_opcode     = slot_q.opcode;
  assign ex_funct3     = slot_q.funct3;
  assign ex_funct7     = slot_q.funct7;
  assign ex_alu_op     = slot_q.ctrl.alu_op;
  assign ex_alu_src    = slot_q.ctrl.alu_src;
  assign ex_branch     = slot_q.ctrl.branch;
  assign ex_mem_write  = slot_q.ctrl.mem_write;
  assign ex_mem_read   = slot_q.ctrl.mem_read;
  assign ex_mem_to_reg = slot_q.ctrl.mem_to_reg;
  assign ex_reg_write  = slot_q.ctrl.reg_write;
  assign ex_pc         = slot_q.pc;
  assign ex_rs1_data   = slot_q.rs1_data;
  assign ex_rs2_data   = slot_q.rs2_data;
  assign ex_imm        = slot_q.imm;
  assign ex_rs1        = slot_q.rs1;
  assign ex_rs2        = slot_q.rs2;
  assign ex_rd         = slot_q.rd;
  assign illegal_op    = illegal_q;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed + randomized bench for id_ex_stage_reg (CNT_W=2 to reach saturation).
module tb_id_ex_stage_reg;
  import riscv_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, id_valid, ex_flush, ex_hold;
  logic [6:0]       id_opcode, id_funct7;
  logic [2:0]       id_funct3;
  logic [1:0]       id_alu_op;
  logic             id_alu_src, id_branch, id_mem_write, id_mem_read, id_mem_to_reg, id_reg_write;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;

  logic             ex_valid, ex_alu_src, ex_branch, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_reg_write;
  logic [6:0]       ex_opcode, ex_funct7;
  logic [2:0]       ex_funct3;
  logic [1:0]       ex_alu_op;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic             stall_if_id, illegal_op;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_branch(id_branch), .id_mem_write(id_mem_write),
    .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_flush(ex_flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .stall_if_id(stall_if_id), .illegal_op(illegal_op), .bubble_cnt(bubble_cnt)
  );

  // Reference model of the EX slot, kept as plain values
  typedef struct packed {
    logic        valid;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [7:0]  ctrl;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
  } slot_t;

  slot_t       m;
  logic        m_ill;
  int unsigned m_cnt;
  logic        last_stall;
  int          errors = 0;
  int          checks = 0;

  localparam logic [6:0] KNOWN [9] = '{OPC_R, OPC_LOAD, OPC_ALUI, OPC_JALR, OPC_STORE,
                                       OPC_BRANCH, OPC_AUIPC, OPC_LUI, OPC_JAL};

  function automatic bit is_known(input logic [6:0] op);
    foreach (KNOWN[i]) if (KNOWN[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return is_known(op) && op != OPC_LUI && op != OPC_AUIPC && op != OPC_JAL;
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op == OPC_R || op == OPC_STORE || op == OPC_BRANCH;
  endfunction

  // {alu_op, alu_src, branch, mem_write, mem_read, mem_to_reg, reg_write}
  function automatic logic [7:0] ctrl_for(input logic [6:0] op);
    case (op)
      OPC_R:      return 8'b10_0_0_0_0_0_1;
      OPC_LOAD:   return 8'b00_1_0_0_1_1_1;
      OPC_ALUI:   return 8'b11_1_0_0_0_0_1;
      OPC_JALR:   return 8'b00_1_0_0_0_0_1;
      OPC_STORE:  return 8'b00_1_0_1_0_0_0;
      OPC_BRANCH: return 8'b01_0_1_0_0_0_0;
      OPC_AUIPC:  return 8'b00_1_0_0_0_0_1;
      OPC_LUI:    return 8'b00_1_0_0_0_0_1;
      OPC_JAL:    return 8'b00_0_0_0_0_0_1;
      default:    return 8'($urandom);
    endcase
  endfunction

  function automatic slot_t id_now();
    slot_t s;
    s.valid = id_valid; s.opcode = id_opcode; s.f3 = id_funct3; s.f7 = id_funct7;
    s.ctrl  = {id_alu_op, id_alu_src, id_branch, id_mem_write, id_mem_read, id_mem_to_reg, id_reg_write};
    s.pc = id_pc; s.rs1d = id_rs1_data; s.rs2d = id_rs2_data; s.imm = id_imm;
    s.rs1 = id_rs1; s.rs2 = id_rs2; s.rd = id_rd;
    return s;
  endfunction

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    logic [7:0] c;
    c = ctrl_for(op);
    id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
    {id_alu_op, id_alu_src, id_branch, id_mem_write, id_mem_read, id_mem_to_reg, id_reg_write} = c;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check stall mid-cycle, advance model at the edge, check EX after it
  task automatic step(input string name);
    bit    hz, stall_exp;
    slot_t nx;
    @(negedge clk);
    hz = m.valid && m.ctrl[2] && m.rd != 0 && id_valid &&
         ((reads_rs1(id_opcode) && id_rs1 == m.rd) || (reads_rs2(id_opcode) && id_rs2 == m.rd));
    stall_exp  = !rst && !ex_flush && (ex_hold || hz);
    last_stall = stall_if_id;
    chk({name, "/stall"}, 128'(stall_if_id), 128'(stall_exp));
    nx = '0;
    @(posedge clk);
    if (rst) begin
      m = '0; m_ill = 0; m_cnt = 0;
    end else if (ex_flush) begin
      m = nx; m_ill = 0;
    end else if (ex_hold) begin
      m_ill = 0;
    end else if (hz) begin
      m = nx; m_ill = 0;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else if (id_valid && !is_known(id_opcode)) begin
      m = nx; m_ill = 1;
    end else if (!id_valid) begin
      m = nx; m_ill = 0;
    end else begin
      m = id_now(); m_ill = 0;
    end
    #1;
    chk({name, "/ex_valid"}, 128'(ex_valid), 128'(m.valid));
    chk({name, "/ctrl"}, 128'({ex_alu_op, ex_alu_src, ex_branch, ex_mem_write, ex_mem_read,
                               ex_mem_to_reg, ex_reg_write}), 128'(m.ctrl));
    chk({name, "/fields"}, 128'({ex_opcode, ex_funct3, ex_funct7, ex_rs1, ex_rs2, ex_rd}),
        128'({m.opcode, m.f3, m.f7, m.rs1, m.rs2, m.rd}));
    chk({name, "/data"}, {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}, {m.pc, m.rs1d, m.rs2d, m.imm});
    chk({name, "/illegal"}, 128'(illegal_op), 128'(m_ill));
    chk({name, "/cnt"}, 128'(bubble_cnt), 128'(m_cnt));
  endtask

  initial begin
    m = '0; m_ill = 0; m_cnt = 0; last_stall = 0;
    rst = 1; ex_flush = 0; ex_hold = 0;
    drive(1, OPC_R, 5'd6, 5'd5, 5'd7);

    // Reset with a valid instruction in ID
    step("rst0"); step("rst1");
    chk("rst/ex_valid", 128'(ex_valid), 128'(0));
    chk("rst/reg_write", 128'(ex_reg_write), 128'(0));
    chk("rst/stall", 128'(last_stall), 128'(0));
    rst = 0;

    // Load-use: lw x5 then add x6,x5,x7
    drive(1, OPC_LOAD, 5'd5, 5'd1, 5'd0); step("lu_lw");
    drive(1, OPC_R, 5'd6, 5'd5, 5'd7);    step("lu_add");
    chk("lu/stall", 128'(last_stall), 128'(1));
    chk("lu/bubble", 128'(ex_valid), 128'(0));
    chk("lu/cnt", 128'(bubble_cnt), 128'(1));
    step("lu_retry");
    chk("lu/add_in_ex", 128'({ex_valid, ex_alu_op}), 128'({1'b1, 2'b10}));

    // No false hazards
    drive(1, OPC_LOAD, 5'd0, 5'd1, 5'd0); step("x0_lw");
    drive(1, OPC_R, 5'd1, 5'd0, 5'd0);    step("x0_add");
    chk("x0/stall", 128'(last_stall), 128'(0));
    drive(1, OPC_LOAD, 5'd5, 5'd1, 5'd0); step("lui_lw");
    drive(1, OPC_LUI, 5'd5, 5'd5, 5'd5);  step("lui");
    chk("lui/stall", 128'(last_stall), 128'(0));
    drive(1, OPC_LOAD, 5'd5, 5'd1, 5'd0); step("addi_lw");
    drive(1, OPC_ALUI, 5'd1, 5'd2, 5'd5); step("addi");
    chk("addi/stall", 128'(last_stall), 128'(0));
    chk("addi/cnt", 128'(bubble_cnt), 128'(1));

    // Flush beats load-use
    drive(1, OPC_LOAD, 5'd5, 5'd1, 5'd0); step("fl_lw");
    drive(1, OPC_R, 5'd6, 5'd5, 5'd5); ex_flush = 1; step("fl_add");
    ex_flush = 0;
    chk("fl/stall", 128'(last_stall), 128'(0));
    chk("fl/bubble", 128'(ex_valid), 128'(0));
    chk("fl/cnt", 128'(bubble_cnt), 128'(1));

    // Hold freezes a store for three cycles
    drive(1, OPC_STORE, 5'd0, 5'd2, 5'd3); step("hd_sw");
    drive(1, OPC_R, 5'd7, 5'd8, 5'd9); ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      step("hd");
      chk("hd/opcode", 128'(ex_opcode), 128'(OPC_STORE));
      chk("hd/stall", 128'(last_stall), 128'(1));
    end
    ex_hold = 0; step("hd_rel");
    chk("hd/released", 128'(ex_opcode), 128'(OPC_R));

    // Illegal opcode becomes a bubble with a one-cycle pulse
    drive(1, 7'b1111111, 5'd3, 5'd4, 5'd5); step("ill");
    chk("ill/bubble", 128'(ex_valid), 128'(0));
    chk("ill/pulse", 128'(illegal_op), 128'(1));
    drive(1, OPC_R, 5'd1, 5'd2, 5'd3); step("ill_next");
    chk("ill/pulse_end", 128'(illegal_op), 128'(0));

    // Saturation: five load-use events on a 2-bit counter
    rst = 1; step("sat_rst"); rst = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, OPC_LOAD, 5'd5, 5'd1, 5'd0); step("sat_lw");
      drive(1, OPC_R, 5'd6, 5'd5, 5'd5);    step("sat_add");
    end
    chk("sat/cnt", 128'(bubble_cnt), 128'(3));

    // Reset during a stall drops the stall immediately
    drive(1, OPC_LOAD, 5'd5, 5'd1, 5'd0); step("rs_lw");
    drive(1, OPC_R, 5'd6, 5'd5, 5'd5); rst = 1; step("rs_add");
    chk("rs/stall", 128'(last_stall), 128'(0));
    chk("rs/ex_valid", 128'(ex_valid), 128'(0));
    rst = 0;

    // Randomized traffic with a small register pool to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      else if ($urandom_range(0, 2) == 0) op = OPC_LOAD;
      else op = KNOWN[$urandom_range(0, 8)];
      drive(logic'($urandom_range(0, 9) != 0), op, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      ex_flush = ($urandom_range(0, 11) == 0);
      ex_hold  = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 59) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
